uart_data_rx: RTL and testbench
===============================

// Module: uart_data_rx
// PURPOSE
// - Receive-side counterpart of the three-channel UART data path: drains three UART RX FIFOs
//   (x, y, level bytes of the remote player) and presents them as registered bytes.
// - Sits between the three UART receivers and the game logic; holds defaults until data arrives.
// - Adds per-channel pop FSMs, a new-data strobe and a link-loss timeout.
// PARAMETERS
// - DEF_1          8'h46      data_out_1 value at reset (start x)
// - DEF_2          8'h08      data_out_2 value at reset (start y)
// - DEF_3          8'h14      data_out_3 value at reset (default level)
// - TIMEOUT_CYCLES 6_500_000  idle cycles with no popped byte before link_lost is asserted
// PORTS
// - clk         in   1  system clock; all logic on posedge
// - rst_n       in   1  asynchronous, active-low reset
// - rx_empty_1  in   1  channel-1 RX FIFO empty flag
// - r_data_1    in   8  channel-1 RX FIFO head word, valid while rx_empty_1=0
// - rd_uart_1   out  1  channel-1 pop; one pop per clk edge at which it is high
// - rx_empty_2/r_data_2/rd_uart_2, rx_empty_3/r_data_3/rd_uart_3: same as channel 1
// - data_out_1  out  8  latest received byte for channel 1 (x); same for data_out_2 (y), data_out_3 (level)
// - new_data    out  1  one-cycle strobe, high in the cycle data_out_* first shows updated values
// - link_lost   out  1  high when no byte popped on any channel for TIMEOUT_CYCLES cycles
// BEHAVIOUR
// - Reset (rst_n=0, async): rd_uart_*=0, data_out_k=DEF_k, new_data=0, link_lost=1,
//   timeout counter=TIMEOUT_CYCLES, all FSMs IDLE, shadows=DEF_k, frame flags=0.
// - All outputs registered; no combinational input-to-output paths.
// - Per-channel FSM, states IDLE -> POP -> WAIT -> IDLE:
//   - IDLE: rx_empty=0 sampled at edge N -> POP. Else stay.
//   - POP (cycle N+1): rd_uart=1; at edge N+1, shadow <= r_data, capture event raised -> WAIT.
//   - WAIT (cycle N+2): rd_uart=0; lets FIFO empty flag settle -> IDLE unconditionally.
//   - Max throughput 1 byte / 3 cycles / channel; rd_uart never high two consecutive cycles.
// - Channels are independent; simultaneous captures on several channels are all honoured.
// - Timeout counter: cleared to 0 at any edge with a capture event on any channel; otherwise
//   increments, saturating at TIMEOUT_CYCLES. link_lost=1 iff counter==TIMEOUT_CYCLES
//   (registered; falls in the cycle after the first capture, rises exactly
//   TIMEOUT_CYCLES cycles after the last capture).
// - data_out_* keep last values on link loss (no revert to defaults).
// - Reset asserted mid-operation: FSM abandons POP/WAIT immediately; a byte whose pop
//   edge was not reached stays in the FIFO.
// - Without UART_RX_SYNC_EN: at each capture edge data_out_k <= r_data_k for capturing
//   channels only; new_data=1 in the following cycle (once even if several channels captured).
//   Latency rx_empty fall (edge N) -> data_out valid: cycle N+2.
// CONFIGURATION
// - UART_RX_SYNC_EN defined: frame-coherent update. Capture writes shadow_k and sets flag_k.
//   When all three flags are set (including the edge that sets the last one), data_out_1..3
//   <= shadow_1..3 together, new_data=1 next cycle, flags cleared. A repeat byte on a
//   flagged channel overwrites its shadow (latest wins). On link_lost rising, flags cleared.
// - UART_RX_SYNC_EN undefined: per-channel immediate update as above; flags/shadow compare unused.
// TESTING
// - Reset: hold rst_n=0 -> data_out=46/08/14 hex, rd_uart_*=0, new_data=0, link_lost=1.
// - Single byte: rx_empty_1 falls with r_data_1=8'hA5 -> rd_uart_1 high for exactly 1 cycle,
//   data_out_1=A5 and new_data=1 two cycles after; link_lost=0 one cycle later; others unchanged.
// - Back-to-back: FIFO_1 holds 11,22,33 -> three rd_uart_1 pulses 3 cycles apart, data_out_1
//   ends 33, three new_data pulses, no pop while rx_empty_1=1.
// - Simultaneous: bytes 10/20/30 on all channels same cycle -> all rd_uart high together,
//   data_out=10/20/30 same cycle, exactly one new_data pulse.
// - Timeout (TIMEOUT_CYCLES=100): one byte then silence -> link_lost rises exactly 100 cycles
//   after capture edge, data_out held; next byte clears it.
// - UART_RX_SYNC_EN: bytes on ch1 (01) then ch1 (02), ch2 (03), ch3 (04) -> data_out stays
//   default until ch3 capture, then 02/03/04 in one cycle with one new_data pulse.

Source files
------------

// File: rtl/uart_data_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_data_rx
// Description : Receive side of the three-channel UART data path. Drains the
//               x, y and level RX FIFOs of the remote player through one pop
//               FSM per channel. Presents the latest bytes as registered
//               outputs, raises a one-cycle new-data strobe, and flags link
//               loss after a programmable idle period.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEF_1 / DEF_2 / DEF_3 : data_out_1..3 value at reset (x, y, level)
//   TIMEOUT_CYCLES        : idle cycles with no popped byte before link_lost
// Ports
//   clk                   : system clock, all logic on rising edge
//   rst_n                 : asynchronous active-low reset
//   rx_empty_k  (in,  1)  : channel-k RX FIFO empty flag
//   r_data_k    (in,  8)  : channel-k RX FIFO head word (valid when !empty)
//   rd_uart_k   (out, 1)  : channel-k FIFO pop, one pop per high clock edge
//   data_out_k  (out, 8)  : latest received byte of channel k
//   new_data    (out, 1)  : one-cycle strobe in the first cycle of new data
//   link_lost   (out, 1)  : no byte popped for TIMEOUT_CYCLES cycles
// Configuration
//   UART_RX_SYNC_EN       : when defined, the outputs update only as a
//                           complete x/y/level frame (all three channels
//                           received since the last update). When undefined,
//                           each channel updates its output on its own.
// ============================================================================
module uart_data_rx #(
    parameter logic [7:0]  DEF_1          = 8'h46,
    parameter logic [7:0]  DEF_2          = 8'h08,
    parameter logic [7:0]  DEF_3          = 8'h14,
    parameter int unsigned TIMEOUT_CYCLES = 6_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_empty_1,
    input  logic [7:0] r_data_1,
    output logic       rd_uart_1,
    input  logic       rx_empty_2,
    input  logic [7:0] r_data_2,
    output logic       rd_uart_2,
    input  logic       rx_empty_3,
    input  logic [7:0] r_data_3,
    output logic       rd_uart_3,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2,
    output logic [7:0] data_out_3,
    output logic       new_data,
    output logic       link_lost
);

    localparam int              c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Channel-indexed views of the flat port list
    logic [2:0] w_empty;
    logic [7:0] w_rdata [3];
    logic [7:0] w_dout  [3];
    logic [2:0] w_rd;
    logic [2:0] w_cap;      // channel pops (and captures) at this edge

    assign w_empty    = {rx_empty_3, rx_empty_2, rx_empty_1};
    assign w_rdata[0] = r_data_1;
    assign w_rdata[1] = r_data_2;
    assign w_rdata[2] = r_data_3;

    // ------------------------------------------------------------------
    // Link-loss timeout counter
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_link_lost;

    always_comb begin
        w_cnt_next = r_cnt;
        if (|w_cap) begin
            w_cnt_next = '0;
        end else if (r_cnt != c_TMO) begin
            w_cnt_next = r_cnt + c_CNT_W'(1);
        end
    end

    // link_lost tracks the counter value it will hold after this edge, so
    // it is high exactly while the counter sits at its saturation value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= c_TMO;
            r_link_lost <= 1'b1;
        end else begin
            r_cnt       <= w_cnt_next;
            r_link_lost <= (w_cnt_next == c_TMO);
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly / strobe
    // ------------------------------------------------------------------
    logic r_new_data;

`ifdef UART_RX_SYNC_EN
    logic [2:0] r_flag;
    logic [2:0] w_flag_set;
    logic       w_frame;      // all three channels present: commit outputs
    logic       w_lost_rise;

    assign w_flag_set  = r_flag | w_cap;
    assign w_frame     = &w_flag_set;
    assign w_lost_rise = (w_cnt_next == c_TMO) && !r_link_lost;

    // A partial frame older than the link timeout is stale; drop it so the
    // next frame starts from scratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag     <= 3'b000;
            r_new_data <= 1'b0;
        end else begin
            if (w_frame || w_lost_rise) begin
                r_flag <= 3'b000;
            end else begin
                r_flag <= w_flag_set;
            end
            r_new_data <= w_frame;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_data <= 1'b0;
        end else begin
            // One strobe even when several channels capture together
            r_new_data <= |w_cap;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Per-channel pop FSM and output register
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        localparam logic [7:0] c_DEF = (gi == 0) ? DEF_1 :
                                       (gi == 1) ? DEF_2 : DEF_3;

        state_t     r_state;
        state_t     w_state_next;
        logic       r_rd;
        logic [7:0] r_dout;

        // IDLE -> POP -> WAIT -> IDLE. WAIT gives the FIFO a cycle to update
        // its empty flag after the pop, so the pop strobe never repeats on
        // back-to-back cycles and never pops an empty FIFO.
        always_comb begin
            w_state_next = r_state;
            case (r_state)
                S_IDLE:  if (!w_empty[gi]) w_state_next = S_POP;
                S_POP:   w_state_next = S_WAIT;
                S_WAIT:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_rd    <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_rd    <= (w_state_next == S_POP);
            end
        end

        // The edge that ends the POP cycle is the pop edge: the FIFO
        // advances and the head word is captured at the same time.
        assign w_cap[gi] = (r_state == S_POP);

`ifdef UART_RX_SYNC_EN
        logic [7:0] r_shadow;
        logic [7:0] w_shadow_next;

        // Latest byte wins; a byte captured on the committing edge is
        // included in the committed frame.
        assign w_shadow_next = w_cap[gi] ? w_rdata[gi] : r_shadow;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow <= c_DEF;
                r_dout   <= c_DEF;
            end else begin
                r_shadow <= w_shadow_next;
                if (w_frame) begin
                    r_dout <= w_shadow_next;
                end
            end
        end
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout <= c_DEF;
            end else if (w_cap[gi]) begin
                r_dout <= w_rdata[gi];
            end
        end
`endif

        assign w_dout[gi] = r_dout;
        assign w_rd[gi]   = r_rd;
    end

    // ------------------------------------------------------------------
    // Outputs (all driven straight from flops)
    // ------------------------------------------------------------------
    assign rd_uart_1  = w_rd[0];
    assign rd_uart_2  = w_rd[1];
    assign rd_uart_3  = w_rd[2];
    assign data_out_1 = w_dout[0];
    assign data_out_2 = w_dout[1];
    assign data_out_3 = w_dout[2];
    assign new_data   = r_new_data;
    assign link_lost  = r_link_lost;

endmodule
`default_nettype wire

// File: tb/tb_uart_data_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_data_rx
// Description : Directed self-checking bench for uart_data_rx. Three queue
//               models stand in for the RX FIFOs. Pins change on the falling
//               edge, and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_data_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty_1 = 1'b1, rx_empty_2 = 1'b1, rx_empty_3 = 1'b1;
    logic [7:0] r_data_1 = 8'h00, r_data_2 = 8'h00, r_data_3 = 8'h00;
    logic       rd_uart_1, rd_uart_2, rd_uart_3;
    logic [7:0] data_out_1, data_out_2, data_out_3;
    logic       new_data, link_lost;

    int vectors    = 0;
    int miscompares = 0;
    int underflow  = 0;

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    uart_data_rx #(
        .DEF_1          (8'h46),
        .DEF_2          (8'h08),
        .DEF_3          (8'h14),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_empty_1 (rx_empty_1),
        .r_data_1   (r_data_1),
        .rd_uart_1  (rd_uart_1),
        .rx_empty_2 (rx_empty_2),
        .r_data_2   (r_data_2),
        .rd_uart_2  (rd_uart_2),
        .rx_empty_3 (rx_empty_3),
        .r_data_3   (r_data_3),
        .rd_uart_3  (rd_uart_3),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .data_out_3 (data_out_3),
        .new_data   (new_data),
        .link_lost  (link_lost)
    );

    always #5 clk = ~clk;

    // FIFO model: pop on each rising edge where the pop strobe is high.
    always @(posedge clk) begin
        if (rd_uart_1) begin
            if (q1.size() == 0) underflow++; else q1.delete(0);
        end
        if (rd_uart_2) begin
            if (q2.size() == 0) underflow++; else q2.delete(0);
        end
        if (rd_uart_3) begin
            if (q3.size() == 0) underflow++; else q3.delete(0);
        end
    end

    task automatic drive_pins();
        rx_empty_1 = (q1.size() == 0);
        rx_empty_2 = (q2.size() == 0);
        rx_empty_3 = (q3.size() == 0);
        r_data_1   = (q1.size() != 0) ? q1[0] : 8'h00;
        r_data_2   = (q2.size() != 0) ? q2[0] : 8'h00;
        r_data_3   = (q3.size() != 0) ? q3[0] : 8'h00;
    endtask

    task automatic tick();
        @(negedge clk);
        drive_pins();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({data_out_1, data_out_2, data_out_3} !== 24'h460814) begin
            $display("FAIL reset_data: got %h/%h/%h want 46/08/14", data_out_1, data_out_2, data_out_3);
            miscompares++;
        end
        vectors++;
        if ({rd_uart_1, rd_uart_2, rd_uart_3} !== 3'b000) begin
            $display("FAIL reset_rd: got %b want 000", {rd_uart_1, rd_uart_2, rd_uart_3});
            miscompares++;
        end
        vectors++;
        if (new_data !== 1'b0) begin
            $display("FAIL reset_new_data: got %b want 0", new_data);
            miscompares++;
        end
        vectors++;
        if (link_lost !== 1'b1) begin
            $display("FAIL reset_link_lost: got %b want 1", link_lost);
            miscompares++;
        end
        rst_n = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({rd_uart_1, new_data, link_lost} !== 3'b001) begin
            $display("FAIL idle_after_reset: got rd/nd/ll=%b want 001", {rd_uart_1, new_data, link_lost});
            miscompares++;
        end
    endtask

    task automatic test_single_byte();
        q1.push_back(8'hA5);
        drive_pins();
        tick();
        vectors++;
        if ({rd_uart_1, data_out_1} !== {1'b1, 8'h46}) begin
            $display("FAIL single_pop: got rd=%b dout=%h want rd=1 dout=46", rd_uart_1, data_out_1);
            miscompares++;
        end
        tick();
        vectors++;
        if ({rd_uart_1, data_out_1, new_data} !== {1'b0, 8'hA5, 1'b1}) begin
            $display("FAIL single_capture: got rd=%b dout=%h nd=%b want rd=0 dout=a5 nd=1", rd_uart_1, data_out_1, new_data);
            miscompares++;
        end
        vectors++;
        if ({data_out_2, data_out_3} !== 16'h0814) begin
            $display("FAIL single_others: got %h/%h want 08/14", data_out_2, data_out_3);
            miscompares++;
        end
        tick();
        vectors++;
        if ({new_data, link_lost, rd_uart_1} !== 3'b000) begin
            $display("FAIL single_after: got nd/ll/rd=%b want 000", {new_data, link_lost, rd_uart_1});
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0, nd = 0, gap_bad = 0, last = -1;
        q1.push_back(8'h11);
        q1.push_back(8'h22);
        q1.push_back(8'h33);
        drive_pins();
        for (int t = 0; t < 15; t++) begin
            tick();
            if (rd_uart_1) begin
                pulses++;
                if (last >= 0 && (t - last) != 3) gap_bad++;
                last = t;
            end
            if (new_data) nd++;
        end
        vectors++;
        if (pulses != 3 || gap_bad != 0) begin
            $display("FAIL b2b_pops: got %0d pulses %0d bad gaps want 3 pulses 0 bad gaps", pulses, gap_bad);
            miscompares++;
        end
        vectors++;
        if (nd != 3) begin
            $display("FAIL b2b_new_data: got %0d pulses want 3", nd);
            miscompares++;
        end
        vectors++;
        if (data_out_1 !== 8'h33) begin
            $display("FAIL b2b_data: got %h want 33", data_out_1);
            miscompares++;
        end
        vectors++;
        if (underflow != 0) begin
            $display("FAIL b2b_empty_pop: got %0d pops of empty FIFO want 0", underflow);
            miscompares++;
        end
    endtask

    task automatic test_simultaneous();
        int nd = 0;
        q1.push_back(8'h10);
        q2.push_back(8'h20);
        q3.push_back(8'h30);
        drive_pins();
        tick();
        vectors++;
        if ({rd_uart_1, rd_uart_2, rd_uart_3} !== 3'b111) begin
            $display("FAIL sim_pop: got %b want 111", {rd_uart_1, rd_uart_2, rd_uart_3});
            miscompares++;
        end
        tick();
        if (new_data) nd++;
        vectors++;
        if ({data_out_1, data_out_2, data_out_3} !== 24'h102030) begin
            $display("FAIL sim_data: got %h/%h/%h want 10/20/30", data_out_1, data_out_2, data_out_3);
            miscompares++;
        end
        repeat (4) begin
            tick();
            if (new_data) nd++;
        end
        vectors++;
        if (nd != 1) begin
            $display("FAIL sim_new_data: got %0d pulses want 1", nd);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        q2.push_back(8'h5A);
        drive_pins();
        tick();
        tick();                // first sample after capture edge C
        repeat (99) tick();    // after edge C+99
        vectors++;
        if (link_lost !== 1'b0) begin
            $display("FAIL timeout_early: got %b want 0 at capture+99", link_lost);
            miscompares++;
        end
        tick();                // after edge C+100
        vectors++;
        if (link_lost !== 1'b1) begin
            $display("FAIL timeout_rise: got %b want 1 at capture+100", link_lost);
            miscompares++;
        end
        vectors++;
        if ({data_out_1, data_out_2, data_out_3} !== 24'h105A30) begin
            $display("FAIL timeout_hold: got %h/%h/%h want 10/5a/30", data_out_1, data_out_2, data_out_3);
            miscompares++;
        end
        q3.push_back(8'h77);
        drive_pins();
        tick();
        tick();
        vectors++;
        if ({link_lost, data_out_3, new_data} !== {1'b0, 8'h77, 1'b1}) begin
            $display("FAIL timeout_recover: got ll=%b dout3=%h nd=%b want ll=0 dout3=77 nd=1", link_lost, data_out_3, new_data);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        tick();
        q1.push_back(8'hBB);
        drive_pins();
        tick();                // channel 1 now in POP
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rd_uart_1, data_out_1} !== {1'b0, 8'h46}) begin
            $display("FAIL midreset_abort: got rd=%b dout=%h want rd=0 dout=46", rd_uart_1, data_out_1);
            miscompares++;
        end
        repeat (2) tick();
        vectors++;
        if (q1.size() != 1) begin
            $display("FAIL midreset_fifo: got %0d entries want 1", q1.size());
            miscompares++;
        end
        rst_n = 1'b1;
        tick();
        tick();
        vectors++;
        if (data_out_1 !== 8'hBB) begin
            $display("FAIL midreset_resume: got %h want bb", data_out_1);
            miscompares++;
        end
    endtask

    task automatic test_sync_frame();
        q1.push_back(8'h01);
        drive_pins();
        repeat (3) tick();
        vectors++;
        if ({data_out_1, new_data} !== {8'h46, 1'b0}) begin
            $display("FAIL sync_partial1: got dout1=%h nd=%b want 46/0", data_out_1, new_data);
            miscompares++;
        end
        q1.push_back(8'h02);
        q2.push_back(8'h03);
        drive_pins();
        repeat (3) tick();
        vectors++;
        if ({data_out_1, data_out_2, data_out_3} !== 24'h460814) begin
            $display("FAIL sync_partial2: got %h/%h/%h want 46/08/14", data_out_1, data_out_2, data_out_3);
            miscompares++;
        end
        q3.push_back(8'h04);
        drive_pins();
        tick();
        vectors++;
        if ({data_out_1, data_out_2, data_out_3, new_data} !== {24'h460814, 1'b0}) begin
            $display("FAIL sync_pending: got %h/%h/%h nd=%b want 46/08/14 nd=0", data_out_1, data_out_2, data_out_3, new_data);
            miscompares++;
        end
        tick();
        vectors++;
        if ({data_out_1, data_out_2, data_out_3} !== 24'h020304) begin
            $display("FAIL sync_commit: got %h/%h/%h want 02/03/04", data_out_1, data_out_2, data_out_3);
            miscompares++;
        end
        vectors++;
        if (new_data !== 1'b1) begin
            $display("FAIL sync_strobe: got %b want 1", new_data);
            miscompares++;
        end
        tick();
        vectors++;
        if (new_data !== 1'b0) begin
            $display("FAIL sync_strobe_end: got %b want 0", new_data);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
`ifdef UART_RX_SYNC_EN
        test_sync_frame();
`else
        test_single_byte();
        test_back_to_back();
        test_simultaneous();
        test_timeout();
        test_reset_mid();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
